mpr121_i2c_responder: RTL and testbench

- Synthesizable I2C target that emulates the MPR121 capacitive-touch controller at the far end of the I2C bus driven by our MPR121 controller (initiator).
- Used in bench loopback and on a second PMOD for board-level bring-up without the sensor fitted.
- Serves touch status from a 12-bit input, stores configuration writes in a shadow register file, and reports each accepted write on a strobe port.

---
 rtl/mpr121_i2c_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_mpr121_i2c_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpr121_i2c_responder.sv
// I2C target that stands in for an MPR121 touch controller: serves a 12-bit
// touch snapshot at 0x00/0x01, keeps a 128-byte shadow file and strobes every written byte.
module mpr121_i2c_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h5A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe_out,
  input  logic [11:0] touch_status_in,
  output logic        wr_valid_out,
  output logic [7:0]  wr_addr_out,
  output logic [7:0]  wr_data_out,
  output logic        busy_out
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_REG      = 3'd3;
  localparam logic [2:0] S_WDATA    = 3'd4;
  localparam logic [2:0] S_RDATA    = 3'd5;
  localparam logic [2:0] S_RACK     = 3'd6;
  localparam logic [2:0] S_IGNORE   = 3'd7;

  function automatic logic [7:0] reg_read(input logic [7:0]  ptr,
                                          input logic [11:0] snap,
                                          input logic [7:0]  shadow_q);
    if (ptr == 8'h00)
      return snap[7:0];
    else if (ptr == 8'h01)
      return {4'b0000, snap[11:8]};
    else if (!ptr[7])
      return shadow_q;
    else
      return 8'h00;
  endfunction

  function automatic logic shadow_hit(input logic [7:0] ptr);
    return !ptr[7] && (ptr[6:1] != 6'd0);
  endfunction

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s, sda_s, scl_prev, sda_prev;
  logic                   scl_rise, scl_fall, bus_start, bus_stop;

  logic [2:0]  state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  pointer, pointer_n;
  logic        sda_oe_n, busy_n, wr_valid_n;
  logic [7:0]  wr_addr_n, wr_data_n;
  logic [7:0]  rx_sr, rx_sr_n, tx_sr, tx_sr_n;
  logic [11:0] snapshot, snapshot_n;
  logic        rw_bit, rw_bit_n;
  logic        shadow_we;
  logic [7:0]  rx_byte, rd_byte, shadow_q;
  logic [7:0]  shadow_mem [0:127];

  // Input synchronizer and edge history
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign bus_start = ~sda_s & sda_prev & scl_s;
  assign bus_stop  = sda_s & ~sda_prev & scl_s;

  assign rx_byte  = {rx_sr[6:0], sda_s};
  assign shadow_q = shadow_mem[pointer[6:0]];
  assign rd_byte  = reg_read(pointer, snapshot, shadow_q);

  // Bit-level protocol engine; bit_cnt runs 0..9 per byte including the ACK slot
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    pointer_n  = pointer;
    sda_oe_n   = sda_oe_out;
    busy_n     = busy_out;
    wr_valid_n = 1'b0;
    wr_addr_n  = wr_addr_out;
    wr_data_n  = wr_data_out;
    rx_sr_n    = rx_sr;
    tx_sr_n    = tx_sr;
    snapshot_n = snapshot;
    rw_bit_n   = rw_bit;
    shadow_we  = 1'b0;

    if (bus_start) begin
      state_n   = S_ADDR;
      bit_cnt_n = 4'd0;
      sda_oe_n  = 1'b0;
    end else if (bus_stop) begin
      state_n   = S_IDLE;
      bit_cnt_n = 4'd0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        S_ADDR: begin
          if (scl_rise) begin
            rx_sr_n   = rx_byte;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              rw_bit_n = sda_s;
              state_n  = (rx_byte[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_n = 1'b1;
            busy_n   = 1'b1;
            if (rw_bit)
              snapshot_n = touch_status_in;
          end else if (scl_rise && bit_cnt == 4'd8) begin
            bit_cnt_n = 4'd9;
          end else if (scl_fall && bit_cnt == 4'd9) begin
            bit_cnt_n = 4'd0;
            if (rw_bit) begin
              sda_oe_n  = ~rd_byte[7];
              tx_sr_n   = {rd_byte[6:0], 1'b0};
              pointer_n = pointer + 8'd1;
              state_n   = S_RDATA;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = S_REG;
            end
          end
        end
        S_REG, S_WDATA: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            rx_sr_n   = rx_byte;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (state == S_REG) begin
                pointer_n = rx_byte;
              end else begin
                wr_valid_n = 1'b1;
                wr_addr_n  = pointer;
                wr_data_n  = rx_byte;
                shadow_we  = shadow_hit(pointer);
                pointer_n  = pointer + 8'd1;
              end
            end
          end else if (scl_rise && bit_cnt == 4'd8) begin
            bit_cnt_n = 4'd9;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_n = 1'b1;
          end else if (scl_fall && bit_cnt == 4'd9) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = 4'd0;
            state_n   = S_WDATA;
          end
        end
        S_RDATA: begin
          // Bit 7 went out on entry; the remaining bits follow each SCL fall
          if (scl_rise && bit_cnt < 4'd8) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_n = 1'b0;
            state_n  = S_RACK;
          end else if (scl_fall && bit_cnt != 4'd0) begin
            sda_oe_n = ~tx_sr[7];
            tx_sr_n  = {tx_sr[6:0], 1'b0};
          end
        end
        S_RACK: begin
          if (scl_rise && bit_cnt == 4'd8) begin
            bit_cnt_n = 4'd9;
            if (sda_s) begin
              state_n = S_IGNORE;
              busy_n  = 1'b0;
            end
          end else if (scl_fall && bit_cnt == 4'd9) begin
            sda_oe_n  = ~rd_byte[7];
            tx_sr_n   = {rd_byte[6:0], 1'b0};
            pointer_n = pointer + 8'd1;
            bit_cnt_n = 4'd0;
            state_n   = S_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= S_IDLE;
      bit_cnt      <= 4'd0;
      pointer      <= 8'h00;
      sda_oe_out   <= 1'b0;
      busy_out     <= 1'b0;
      wr_valid_out <= 1'b0;
      wr_addr_out  <= 8'h00;
      wr_data_out  <= 8'h00;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      pointer      <= pointer_n;
      sda_oe_out   <= sda_oe_n;
      busy_out     <= busy_n;
      wr_valid_out <= wr_valid_n;
      wr_addr_out  <= wr_addr_n;
      wr_data_out  <= wr_data_n;
    end
  end

  // Datapath registers and shadow file carry no reset
  always_ff @(posedge clk_in) begin
    rx_sr    <= rx_sr_n;
    tx_sr    <= tx_sr_n;
    snapshot <= snapshot_n;
    rw_bit   <= rw_bit_n;
    if (shadow_we)
      shadow_mem[pointer[6:0]] <= rx_byte;
  end

endmodule

// File: tb/tb_mpr121_i2c_responder.sv
// Directed bench for mpr121_i2c_responder: a bit-banged I2C master drives the bus,
// expected write strobes and read bytes go into queues checked by a separate monitor.
module tb_mpr121_i2c_responder;

  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic [11:0] touch = 12'h000;
  logic        sda_oe, wr_valid, busy;
  logic [7:0]  wr_addr, wr_data;
  logic        sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  mpr121_i2c_responder #(.DEV_ADDR(7'h5A), .SYNC_STAGES(2)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .scl_in(scl),
    .sda_in(sda_bus),
    .sda_oe_out(sda_oe),
    .touch_status_in(touch),
    .wr_valid_out(wr_valid),
    .wr_addr_out(wr_addr),
    .wr_data_out(wr_data),
    .busy_out(busy)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int          oe_rises = 0;
  logic        oe_prev = 1'b0;
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  rd_got [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, expv);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [15:0] e;
    logic [7:0]  g, r;
    if (sda_oe && !oe_prev) oe_rises++;
    oe_prev = sda_oe;
    if (wr_valid) begin
      if (exp_wr.size() == 0) begin
        n_checks++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, required no strobe", wr_addr, wr_data);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_strobe", {16'h0, wr_addr, wr_data}, {16'h0, e});
      end
    end
    if (rd_got.size() > 0) begin
      g = rd_got.pop_front();
      if (exp_rd.size() == 0) begin
        n_checks++;
        $display("FAIL rd_unexpected: got 0x%0h, required no byte", g);
      end else begin
        r = exp_rd.pop_front();
        chk("rd_byte", {24'h0, g}, {24'h0, r});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "bench timeout");
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b0; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    ack = sda_bus; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic tx_ack(input string name, input logic [7:0] b);
    logic a;
    send_byte(b, a);
    chk(name, 32'(a), 32'd0);
  endtask

  task automatic read_byte(input logic [7:0] expected, input logic master_ack);
    logic [7:0] v;
    exp_rd.push_back(expected);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_q();
      scl = 1'b1; wait_q();
      v[i] = sda_bus; wait_q();
      scl = 1'b0; wait_q();
    end
    sda_m = master_ack ? 1'b0 : 1'b1; wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0;
    sda_m = 1'b1; wait_q();
    rd_got.push_back(v);
  endtask

  initial begin
    int  oe0;
    logic a;

    repeat (10) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single write to 0x5E
    oe0 = oe_rises;
    i2c_start();
    tx_ack("w1_addr_ack", 8'hB4);
    chk("w1_busy", 32'(busy), 32'd1);
    tx_ack("w1_ptr_ack", 8'h5E);
    exp_wr.push_back({8'h5E, 8'h0C});
    tx_ack("w1_data_ack", 8'h0C);
    i2c_stop();
    chk("w1_ack_pulses", 32'(oe_rises - oe0), 32'd3);
    chk("w1_busy_after_stop", 32'(busy), 32'd0);

    // Touch readback with coherent snapshot
    touch = 12'hA5A;
    i2c_start();
    tx_ack("t_addr_ack", 8'hB4);
    tx_ack("t_ptr_ack", 8'h00);
    i2c_start();
    tx_ack("t_raddr_ack", 8'hB5);
    read_byte(8'h5A, 1'b1);
    touch = 12'h333;
    read_byte(8'h0A, 1'b0);
    chk("t_busy_after_nack", 32'(busy), 32'd0);
    i2c_stop();

    // Shadow burst write then read back
    i2c_start();
    tx_ack("s_addr_ack", 8'hB4);
    tx_ack("s_ptr_ack", 8'h20);
    exp_wr.push_back({8'h20, 8'h11});
    tx_ack("s_d0_ack", 8'h11);
    exp_wr.push_back({8'h21, 8'h22});
    tx_ack("s_d1_ack", 8'h22);
    i2c_stop();
    i2c_start();
    tx_ack("s_addr2_ack", 8'hB4);
    tx_ack("s_ptr2_ack", 8'h20);
    i2c_start();
    tx_ack("s_raddr_ack", 8'hB5);
    read_byte(8'h11, 1'b1);
    read_byte(8'h22, 1'b0);
    i2c_stop();

    // Address mismatch is ignored
    oe0 = oe_rises;
    i2c_start();
    send_byte(8'hB6, a);
    chk("mm_addr_nack", 32'(a), 32'd1);
    send_byte(8'h12, a);
    send_byte(8'h34, a);
    send_byte(8'h56, a);
    chk("mm_data_nack", 32'(a), 32'd1);
    i2c_stop();
    chk("mm_no_oe", 32'(oe_rises - oe0), 32'd0);
    chk("mm_busy", 32'(busy), 32'd0);
    i2c_start();
    tx_ack("mm_next_ack", 8'hB4);
    i2c_stop();

    // Pointer wrap on read and write
    touch = 12'h700;
    i2c_start();
    tx_ack("pw_addr_ack", 8'hB4);
    tx_ack("pw_ptr_ack", 8'hFF);
    i2c_start();
    tx_ack("pw_raddr_ack", 8'hB5);
    read_byte(8'h00, 1'b1);
    read_byte(8'h00, 1'b0);
    i2c_stop();
    i2c_start();
    tx_ack("pw_persist_ack", 8'hB5);
    read_byte(8'h07, 1'b0);
    i2c_stop();
    i2c_start();
    tx_ack("ww_addr_ack", 8'hB4);
    tx_ack("ww_ptr_ack", 8'hFF);
    exp_wr.push_back({8'hFF, 8'h5D});
    tx_ack("ww_d0_ack", 8'h5D);
    exp_wr.push_back({8'h00, 8'h6E});
    tx_ack("ww_d1_ack", 8'h6E);
    i2c_stop();
    i2c_start();
    tx_ack("ro_addr_ack", 8'hB4);
    tx_ack("ro_ptr_ack", 8'h00);
    i2c_start();
    tx_ack("ro_raddr_ack", 8'hB5);
    read_byte(8'h00, 1'b1);
    read_byte(8'h07, 1'b0);
    i2c_stop();

    // STOP after 4 bits of a data byte
    i2c_start();
    tx_ack("ab_addr_ack", 8'hB4);
    tx_ack("ab_ptr_ack", 8'h50);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    chk("ab_busy", 32'(busy), 32'd0);

    // Repeated START while serving read data
    i2c_start();
    tx_ack("rs_addr_ack", 8'hB4);
    tx_ack("rs_ptr_ack", 8'h40);
    exp_wr.push_back({8'h40, 8'h9C});
    tx_ack("rs_d_ack", 8'h9C);
    i2c_stop();
    i2c_start();
    tx_ack("rs_addr2_ack", 8'hB4);
    tx_ack("rs_ptr2_ack", 8'h40);
    i2c_start();
    tx_ack("rs_raddr_ack", 8'hB5);
    i2c_start();
    tx_ack("rs_restart_ack", 8'hB4);
    tx_ack("rs_ptr3_ack", 8'h60);
    i2c_stop();

    // Asynchronous reset while a 0 data bit is on the bus
    i2c_start();
    tx_ack("rr_addr_ack", 8'hB4);
    tx_ack("rr_ptr_ack", 8'h20);
    i2c_start();
    tx_ack("rr_raddr_ack", 8'hB5);
    chk("rr_bit0_driven", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("rr_async_release", 32'(sda_oe), 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    i2c_stop();
    i2c_start();
    tx_ack("rr_recover_ack", 8'hB4);
    i2c_stop();

    repeat (20) @(negedge clk);
    chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
